button_event_decoder: RTL
=========================

# button_event_decoder

Converts one debounced, synchronised button level into single-cycle UI events for the clock-setting logic: short press (emitted on release), long press (emitted once when the hold threshold is reached), and auto-repeat while held. It sits directly downstream of the per-button debouncer and upstream of the time-set/mode FSM. Hold timing counts a shared 1 ms enable strobe, so counters stay small at 10 MHz.

## Interface
- `LONG_MS`, default 1000: hold time in ms before the long-press and first repeat fire; legal range ≥ 2.
- `REPEAT_MS`, default 200: interval in ms between auto-repeat pulses after the long press; legal range ≥ 1.
- `i_clk`  input  1  system clock (10 MHz).
- `i_rst`  input  1  synchronous, active-high reset.
- `i_tick`  input  1  1 ms enable strobe, one cycle wide; may be tied high in simulation.
- `i_btn`  input  1  debounced button level, already synchronous to `i_clk`; 1 = pressed.
- `o_short`  output  1  one-cycle pulse: button released before `LONG_MS`.
- `o_long`  output  1  one-cycle pulse: hold reached `LONG_MS`.
- `o_repeat`  output  1  one-cycle pulse: fires at `LONG_MS`, then every `REPEAT_MS` while held.
- `o_held`  output  1  level: 1 while in PRESSED or LONG.

## Operation
- Sample point: all decisions use `i_btn`/`i_tick` as sampled at the current rising edge. All outputs are registered.
- Hold counter `cnt`: width `$clog2(max(LONG_MS,REPEAT_MS))`. It is cleared on every state entry and increments only on cycles where `i_tick`=1.
- States:
  - IDLE: `i_btn`=1 → PRESSED, `cnt`←0.
  - PRESSED:
    - `i_btn`=0 → IDLE and `o_short` pulses.
    - Otherwise, if `i_tick`=1 and `cnt`==`LONG_MS`-1 → LONG, `cnt`←0, `o_long`=1 and `o_repeat`=1 together.
  - LONG:
    - `i_btn`=0 → IDLE, with no pulse.
    - Otherwise, if `i_tick`=1 and `cnt`==`REPEAT_MS`-1 → `o_repeat` pulses and `cnt`←0.
- Simultaneous events:
  - Release sampled on the same edge as a threshold tick: release wins. In PRESSED this gives `o_short` only. In LONG it gives no pulse.
  - Press sampled in IDLE with `i_tick`=1: the counter does not count that tick. Counting starts on the next edge.
- At most one of `o_short` / `o_long` is asserted in any cycle. `o_short` and `o_repeat` are never asserted together.
- Re-press immediately after release (`i_btn` 1,0,1 on consecutive edges): legal. Gives PRESSED→IDLE→PRESSED with a fresh count.
- Reset:
  - Reset values: state IDLE, `cnt`=0, `o_short`=`o_long`=`o_repeat`=`o_held`=0.
  - Reset mid-hold drops to IDLE with no pulse.
  - If `i_btn` is still 1 after reset deasserts, it is treated as a new press: PRESSED on the first non-reset edge.

## Timing
- Latency: the pulse or `o_held` change is visible in the cycle after the edge at which the causing input was sampled.
- Pulse width: exactly 1 `i_clk` cycle, independent of `i_tick` width.
- Long press: `o_long` appears after exactly `LONG_MS` ticks sampled while in PRESSED. The first tick counted is the one on the edge after entry.
- Repeat spacing: exactly `REPEAT_MS` ticks between successive `o_repeat` pulses.
- `o_held` rises one cycle after the press is sampled. It falls one cycle after the release is sampled, in the same cycle as `o_short`.

## Structure
- Shared package `clock_ui_pkg`:
  - State typedef `btn_state_t` {IDLE, PRESSED, LONG}.
  - Default constants `LONG_MS_DEF` and `REPEAT_MS_DEF`, shared with the time-set FSM.
- One natural sub-module `hold_timer`:
  - Tick-enabled counter with synchronous clear.
  - Terminal-compare input `i_limit`, output `o_hit` = tick && cnt==limit-1.
  - The decoder selects `LONG_MS` or `REPEAT_MS` as the limit by state.
- The decoder is instantiated once per button. The debouncer output feeds `i_btn` directly.

## Test plan
All scenarios use `LONG_MS`=4, `REPEAT_MS`=2 and `i_tick` tied to 1.
- Short press: `i_btn`=1 for 3 cycles, then 0 → exactly one `o_short`, one cycle after release is sampled. No `o_long`, no `o_repeat`. `o_held` high for 3 cycles.
- Long hold: `i_btn`=1 for 12 cycles.
  - `o_long`+`o_repeat` together in cycle 5.
  - `o_repeat` again in cycles 7, 9 and 11.
  - No `o_short` on release.
- Boundary tie: release sampled on the same edge as the 4th tick → `o_short` only, no `o_long`.
- Sparse tick: `i_tick` driven 1-in-10 cycles, button held → `o_long` after the 4th sampled tick. Pulses stay 1 cycle wide.
- Reset mid-hold: `i_rst` asserted in LONG with `i_btn` still 1.
  - All outputs 0 during reset.
  - After reset deasserts: PRESSED, then `o_long` 4 cycles later.
- Rapid re-press: `i_btn` 1,0,1,0 on consecutive edges → two `o_short` pulses, two cycles apart.

Source files
------------

// File: rtl/clock_ui_pkg.sv
// clock_ui_pkg
// Shared definitions for the clock-setting UI: button decoder state type,
// default hold/repeat timings (also used by the time-set FSM) and a helper
// that sizes the hold counter.
package clock_ui_pkg;

  localparam int LONG_MS_DEF   = 1000;
  localparam int REPEAT_MS_DEF = 200;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } btn_state_t;

  // Counter width: $clog2(max(long_ms, repeat_ms)), never below 1 bit.
  function automatic int hold_cnt_w(input int long_ms, input int repeat_ms);
    int m;
    m = (long_ms > repeat_ms) ? long_ms : repeat_ms;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// hold_timer
// Tick-enabled hold counter with synchronous clear and terminal compare.
// Ports:
//   i_clk    system clock
//   i_rst    synchronous active-high reset
//   i_tick   count enable (1 ms strobe)
//   i_clr    synchronous clear, takes priority over counting
//   i_limit  terminal count; o_hit fires when cnt == i_limit-1 on a tick
//   o_hit    combinational terminal-count indication (i_tick && cnt==limit-1)
module hold_timer #(
  parameter int CNT_W = 10
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_tick,
  input  logic           i_clr,
  input  logic [CNT_W:0] i_limit,
  output logic           o_hit
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_last;

  // Limit is one bit wider than the counter so the full limit value fits.
  assign w_last = i_limit - (CNT_W+1)'(1);
  assign o_hit  = i_tick && ({1'b0, r_cnt} == w_last);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder
// Turns a debounced, synchronous button level into one-cycle UI events:
// short press (on release), long press (once at LONG_MS) and auto-repeat
// (at LONG_MS, then every REPEAT_MS while held). Hold time is measured in
// 1 ms ticks.
// Ports:
//   i_clk     system clock
//   i_rst     synchronous active-high reset
//   i_tick    1 ms enable strobe
//   i_btn     debounced button level, 1 = pressed
//   o_short   pulse: released before LONG_MS
//   o_long    pulse: hold reached LONG_MS
//   o_repeat  pulse: at LONG_MS and every REPEAT_MS after while held
//   o_held    level: button is in a pressed state (PRESSED or LONG)
module button_event_decoder
  import clock_ui_pkg::*;
#(
  parameter int LONG_MS   = LONG_MS_DEF,
  parameter int REPEAT_MS = REPEAT_MS_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_short,
  output logic o_long,
  output logic o_repeat,
  output logic o_held
);

  localparam int CNT_W = hold_cnt_w(LONG_MS, REPEAT_MS);
  localparam int LIM_W = CNT_W + 1;
  localparam logic [LIM_W-1:0] LIM_LONG   = LIM_W'(LONG_MS);
  localparam logic [LIM_W-1:0] LIM_REPEAT = LIM_W'(REPEAT_MS);

  btn_state_t       r_state;
  logic             r_short;
  logic             r_long;
  logic             r_repeat;
  logic             r_held;
  logic             w_hit;
  logic             w_clr;
  logic [LIM_W-1:0] w_limit;

  assign w_limit = (r_state == LONG) ? LIM_REPEAT : LIM_LONG;

  // Counter is held at zero in IDLE, so entering PRESSED always starts from
  // zero and a tick on the press edge is not counted. Clearing on release
  // and on each hit gives every state entry / repeat interval a fresh count.
  assign w_clr = (r_state == IDLE) || !i_btn || w_hit;

  hold_timer #(
    .CNT_W (CNT_W)
  ) u_hold_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_tick  (i_tick),
    .i_clr   (w_clr),
    .i_limit (w_limit),
    .o_hit   (w_hit)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      r_held   <= 1'b0;
    end else begin
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_btn) begin
            r_state <= PRESSED;
            r_held  <= 1'b1;
          end else begin
            r_held  <= 1'b0;
          end
        end
        PRESSED: begin
          // Release wins over a coincident threshold tick.
          if (!i_btn) begin
            r_state <= IDLE;
            r_short <= 1'b1;
            r_held  <= 1'b0;
          end else if (w_hit) begin
            r_state  <= LONG;
            r_long   <= 1'b1;
            r_repeat <= 1'b1;
            r_held   <= 1'b1;
          end else begin
            r_held   <= 1'b1;
          end
        end
        LONG: begin
          if (!i_btn) begin
            r_state <= IDLE;
            r_held  <= 1'b0;
          end else begin
            r_held  <= 1'b1;
            if (w_hit) begin
              r_repeat <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign o_short  = r_short;
  assign o_long   = r_long;
  assign o_repeat = r_repeat;
  assign o_held   = r_held;

endmodule
